// File: rtl/cpu_pkg.sv
// Instruction-format codes shared with the 16-bit serial CPU.
// The format lives in bits [3:0] of the first instruction word.
package cpu_pkg;

    localparam logic [3:0] R_TYPE = 4'h0;
    localparam logic [3:0] I_TYPE = 4'h1;
    localparam logic [3:0] M_TYPE = 4'h2;
    localparam logic [3:0] J_TYPE = 4'h3;

endpackage : cpu_pkg

// File: rtl/serial_bus_pkg.sv
// Shared types for the memory side of the byte-serial CPU bus: bridge states,
// the instruction-format codes and the one-or-two-word fetch decision.
package serial_bus_pkg;

    typedef enum logic [2:0] {
        RESET,
        IDLE,
        ADDR_HI,
        RESP,
        WR_LO,
        WR_HI,
        HALT
    } bridge_state_t;

    localparam logic [3:0] R_TYPE = cpu_pkg::R_TYPE;
    localparam logic [3:0] I_TYPE = cpu_pkg::I_TYPE;
    localparam logic [3:0] M_TYPE = cpu_pkg::M_TYPE;
    localparam logic [3:0] J_TYPE = cpu_pkg::J_TYPE;

    // I- and M-type instructions carry a second word (immediate / address).
    function automatic logic is_two_word(input logic [3:0] fmt);
        return (fmt == I_TYPE) || (fmt == M_TYPE);
    endfunction

endpackage : serial_bus_pkg

// File: rtl/serial_word_mem.sv
// Register-array word memory: asynchronous read, synchronous write.
// Two write requesters share the array; on the same word the primary wins,
// on different words both are written in the same cycle.
module serial_word_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o,
    input  logic          pri_we_i,
    input  logic [AW-1:0] pri_addr_i,
    input  logic [15:0]   pri_data_i,
    input  logic          sec_we_i,
    input  logic [AW-1:0] sec_addr_i,
    input  logic [15:0]   sec_data_i
);

    logic [15:0] mem_q [DEPTH];

    // Per-word write with primary-over-secondary priority.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (pri_we_i && (pri_addr_i == AW'(i))) begin
                mem_q[i] <= pri_data_i;
            end else if (sec_we_i && (sec_addr_i == AW'(i))) begin
                mem_q[i] <= sec_data_i;
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : serial_word_mem

// File: rtl/serial_mem_bridge.sv
// Memory-side bridge for the byte-serial CPU bus: decodes fetch/load/store
// requests, streams response bytes low-first, and hosts imem/dmem with a
// host preload port.
module serial_mem_bridge
    import serial_bus_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 16,
    parameter int unsigned DMEM_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  out_bus,
    input  logic        bus_pc,
    input  logic        bus_mar,
    input  logic        bus_mdr,
    input  logic        halt,
    output logic [7:0]  in_bus,
    output logic        data_ready,
    output logic        receive_ready,
    input  logic        load_en,
    input  logic        load_sel,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    output logic        halted
);

    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);

    bridge_state_t state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   data_q, data_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          fetch_q, fetch_d;
    logic          two_word_q, two_word_d;
    logic [7:0]    in_bus_q, in_bus_d;
    logic          data_ready_q, data_ready_d;
    logic          receive_ready_q, receive_ready_d;
    logic          halted_q, halted_d;

    logic [15:0]   addr_cur;
    logic          imem_next;
    logic [15:0]   imem_rdata;
    logic [15:0]   dmem_rdata;
    logic          dmem_we;
    logic [15:0]   dmem_wdata;
    logic          unused_bits;

    // The high address byte is still on out_bus during ADDR_HI, so the first
    // response byte is read with the full address before it is registered.
    assign addr_cur    = (state_q == ADDR_HI) ? {out_bus, addr_q[7:0]} : addr_q;
    assign unused_bits = ^{addr_cur, data_q[7:0], load_addr};

    serial_word_mem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (IAW)
    ) u_imem (
        .clk_i      (clock),
        .raddr_i    (addr_cur[IAW-1:0] + IAW'(imem_next)),
        .rdata_o    (imem_rdata),
        .pri_we_i   (1'b0),
        .pri_addr_i ('0),
        .pri_data_i ('0),
        .sec_we_i   (load_en && !load_sel),
        .sec_addr_i (load_addr[IAW-1:0]),
        .sec_data_i (load_data)
    );

    serial_word_mem #(
        .DEPTH (DMEM_DEPTH),
        .AW    (DAW)
    ) u_dmem (
        .clk_i      (clock),
        .raddr_i    (addr_cur[DAW-1:0]),
        .rdata_o    (dmem_rdata),
        .pri_we_i   (dmem_we),
        .pri_addr_i (addr_q[DAW-1:0]),
        .pri_data_i (dmem_wdata),
        .sec_we_i   (load_en && load_sel),
        .sec_addr_i (load_addr[DAW-1:0]),
        .sec_data_i (load_data)
    );

    // State, shift registers and registered bus outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= RESET;
            addr_q          <= '0;
            data_q          <= '0;
            cnt_q           <= '0;
            fetch_q         <= 1'b0;
            two_word_q      <= 1'b0;
            in_bus_q        <= '0;
            data_ready_q    <= 1'b0;
            receive_ready_q <= 1'b0;
            halted_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            cnt_q           <= cnt_d;
            fetch_q         <= fetch_d;
            two_word_q      <= two_word_d;
            in_bus_q        <= in_bus_d;
            data_ready_q    <= data_ready_d;
            receive_ready_q <= receive_ready_d;
            halted_q        <= halted_d;
        end
    end

    // Request decode, response byte sequencing and store commit.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        data_d          = data_q;
        cnt_d           = cnt_q;
        fetch_d         = fetch_q;
        two_word_d      = two_word_q;
        in_bus_d        = in_bus_q;
        data_ready_d    = 1'b0;
        receive_ready_d = receive_ready_q;
        halted_d        = halted_q;
        imem_next       = 1'b0;
        dmem_we         = 1'b0;
        dmem_wdata      = {out_bus, data_q[15:8]};

        case (state_q)
            RESET: begin
                state_d         = IDLE;
                receive_ready_d = 1'b1;
            end
            IDLE: begin
                if (bus_pc || bus_mar) begin
                    addr_d[7:0] = out_bus;
                    fetch_d     = bus_pc;
                    state_d     = ADDR_HI;
                end else if (halt) begin
                    state_d         = HALT;
                    receive_ready_d = 1'b0;
                    halted_d        = 1'b1;
                end
            end
            ADDR_HI: begin
                addr_d[15:8] = out_bus;
                cnt_d        = '0;
                if (fetch_q || !bus_mdr) begin
                    in_bus_d        = fetch_q ? imem_rdata[7:0] : dmem_rdata[7:0];
                    two_word_d      = fetch_q && is_two_word(imem_rdata[3:0]);
                    data_ready_d    = 1'b1;
                    receive_ready_d = 1'b0;
                    state_d         = RESP;
                end else begin
                    state_d = WR_LO;
                end
            end
            RESP: begin
                // cnt_q is the byte currently on in_bus; bytes 2/3 come from word a+1.
                imem_next = (cnt_q != 2'd0);
                case (cnt_q)
                    2'd0: begin
                        in_bus_d     = fetch_q ? imem_rdata[15:8] : dmem_rdata[15:8];
                        data_ready_d = 1'b1;
                        cnt_d        = 2'd1;
                    end
                    2'd1: begin
                        if (two_word_q) begin
                            in_bus_d     = imem_rdata[7:0];
                            data_ready_d = 1'b1;
                            cnt_d        = 2'd2;
                        end else begin
                            receive_ready_d = 1'b1;
                            state_d         = IDLE;
                        end
                    end
                    2'd2: begin
                        in_bus_d     = imem_rdata[15:8];
                        data_ready_d = 1'b1;
                        cnt_d        = 2'd3;
                    end
                    2'd3: begin
                        receive_ready_d = 1'b1;
                        state_d         = IDLE;
                    end
                endcase
            end
            WR_LO: begin
                data_d  = {out_bus, data_q[15:8]};
                state_d = WR_HI;
            end
            WR_HI: begin
                data_d  = {out_bus, data_q[15:8]};
                dmem_we = 1'b1;
                state_d = IDLE;
            end
            HALT: begin
                receive_ready_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_bus        = in_bus_q;
    assign data_ready    = data_ready_q;
    assign receive_ready = receive_ready_q;
    assign halted        = halted_q;

endmodule : serial_mem_bridge

// File: tb/tb_serial_mem_bridge.sv
// Scoreboard bench for serial_mem_bridge: stimulus pushes expected response
// bytes, a negedge monitor pops and compares whenever data_ready is high.
module tb_serial_mem_bridge;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  out_bus = '0;
    logic        bus_pc = 1'b0;
    logic        bus_mar = 1'b0;
    logic        bus_mdr = 1'b0;
    logic        halt = 1'b0;
    logic [7:0]  in_bus;
    logic        data_ready;
    logic        receive_ready;
    logic        load_en = 1'b0;
    logic        load_sel = 1'b0;
    logic [15:0] load_addr = '0;
    logic [15:0] load_data = '0;
    logic        halted;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];

    serial_mem_bridge #(
        .IMEM_DEPTH (16),
        .DMEM_DEPTH (16)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .out_bus       (out_bus),
        .bus_pc        (bus_pc),
        .bus_mar       (bus_mar),
        .bus_mdr       (bus_mdr),
        .halt          (halt),
        .in_bus        (in_bus),
        .data_ready    (data_ready),
        .receive_ready (receive_ready),
        .load_en       (load_en),
        .load_sel      (load_sel),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .halted        (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every presented byte must match the next expected one.
    always @(negedge clock) begin
        if (reset_n && data_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_byte: got %h, expected no response (t=%0t)", in_bus, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (in_bus !== e) begin
                    n_fail++;
                    $display("FAIL resp_byte: got %h, expected %h (t=%0t)", in_bus, e, $time);
                end
            end
        end
    end

    task automatic preload(input logic sel, input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        load_en = 1'b1; load_sel = sel; load_addr = a; load_data = d;
        @(negedge clock);
        load_en = 1'b0;
    endtask

    // Fetch (or load when is_fetch=0); also_mar raises bus_mar with bus_pc.
    task automatic request(input logic is_fetch, input logic also_mar,
                           input logic [15:0] a, input int nb, input string tag);
        @(negedge clock);
        check({tag, "_rr_before"}, receive_ready, 1'b1);
        bus_pc = is_fetch; bus_mar = !is_fetch || also_mar; bus_mdr = also_mar;
        out_bus = a[7:0];
        @(negedge clock);
        bus_pc = 1'b0; bus_mar = 1'b0; out_bus = a[15:8];
        for (int i = 0; i < nb; i++) begin
            @(negedge clock);
            bus_mdr = 1'b0; out_bus = 8'h00;
            check({tag, "_dr_resp"}, data_ready, 1'b1);
            check({tag, "_rr_resp"}, receive_ready, 1'b0);
        end
        @(negedge clock);
        check({tag, "_dr_after"}, data_ready, 1'b0);
        check({tag, "_rr_after"}, receive_ready, 1'b1);
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d,
                         input logic conflict, input logic abort, input string tag);
        @(negedge clock);
        bus_mar = 1'b1; bus_mdr = 1'b1; out_bus = a[7:0];
        @(negedge clock);
        bus_mar = 1'b0; out_bus = a[15:8];
        @(negedge clock);
        out_bus = d[7:0];
        check({tag, "_rr_wrlo"}, receive_ready, 1'b1);
        check({tag, "_dr_wrlo"}, data_ready, 1'b0);
        @(negedge clock);
        bus_mdr = 1'b0; out_bus = d[15:8];
        check({tag, "_rr_wrhi"}, receive_ready, 1'b1);
        if (conflict) begin
            load_en = 1'b1; load_sel = 1'b1; load_addr = a; load_data = 16'hFFFF;
        end
        if (abort) reset_n = 1'b0;
        @(negedge clock);
        load_en = 1'b0; out_bus = 8'h00;
        if (abort) begin
            check({tag, "_rr_in_reset"}, receive_ready, 1'b0);
            reset_n = 1'b1;
            @(negedge clock);
        end
        check({tag, "_rr_after"}, receive_ready, 1'b1);
        check({tag, "_dr_after"}, data_ready, 1'b0);
    endtask

    initial begin
        // 1: reset with random request inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            out_bus = 8'($urandom); bus_pc = 1'($urandom); bus_mar = 1'($urandom);
            bus_mdr = 1'($urandom); halt = 1'($urandom);
            check("reset_in_bus", in_bus, 8'h00);
            check("reset_dr", data_ready, 1'b0);
            check("reset_rr", receive_ready, 1'b0);
            check("reset_halted", halted, 1'b0);
        end
        bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b0; halt = 1'b0; out_bus = 8'h00;
        reset_n = 1'b1;
        @(negedge clock);
        check("post_reset_rr", receive_ready, 1'b1);

        // 2: R-type fetch, two bytes
        preload(1'b0, 16'd5, 16'h1230);
        exp_q.push_back(8'h30); exp_q.push_back(8'h12);
        request(1'b1, 1'b0, 16'h0005, 2, "fetch_r");

        // 3: I-type fetch wrapping 15 -> 0, aliased address, M-type and J-type
        preload(1'b0, 16'd15, 16'hABC1);
        preload(1'b0, 16'd0, 16'h0005);
        preload(1'b0, 16'd7, 16'h4442);
        preload(1'b0, 16'd8, 16'h9988);
        preload(1'b0, 16'd9, 16'h0013);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(8'hC1); exp_q.push_back(8'hAB);
            exp_q.push_back(8'h05); exp_q.push_back(8'h00);
            request(1'b1, 1'b0, (k == 0) ? 16'h000F : 16'h001F, 4, "fetch_i_wrap");
        end
        exp_q.push_back(8'h42); exp_q.push_back(8'h44);
        exp_q.push_back(8'h88); exp_q.push_back(8'h99);
        request(1'b1, 1'b0, 16'h0007, 4, "fetch_m");
        exp_q.push_back(8'h13); exp_q.push_back(8'h00);
        request(1'b1, 1'b0, 16'h0009, 2, "fetch_j");

        // 4: store then load
        store(16'h0004, 16'h000B, 1'b0, 1'b0, "store1");
        exp_q.push_back(8'h0B); exp_q.push_back(8'h00);
        request(1'b0, 1'b0, 16'h0004, 2, "load1");

        // 5: store beats same-cycle preload; reset at WR_HI commits nothing
        preload(1'b1, 16'd4, 16'h1234);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        request(1'b0, 1'b0, 16'h0004, 2, "load_pre");
        store(16'h0004, 16'h000B, 1'b1, 1'b0, "store_conflict");
        exp_q.push_back(8'h0B); exp_q.push_back(8'h00);
        request(1'b0, 1'b0, 16'h0004, 2, "load_conflict");
        store(16'h0004, 16'h5A5A, 1'b0, 1'b1, "store_abort");
        exp_q.push_back(8'h0B); exp_q.push_back(8'h00);
        request(1'b0, 1'b0, 16'h0004, 2, "load_abort");

        // 6: bus_pc wins over bus_mar; halt is sticky and blocks requests
        exp_q.push_back(8'h30); exp_q.push_back(8'h12);
        request(1'b1, 1'b1, 16'h0005, 2, "prio");
        @(negedge clock);
        halt = 1'b1;
        @(negedge clock);
        halt = 1'b0;
        check("halt_halted", halted, 1'b1);
        check("halt_rr", receive_ready, 1'b0);
        bus_pc = 1'b1; out_bus = 8'h05;
        @(negedge clock);
        bus_pc = 1'b0; out_bus = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("halt_no_resp", data_ready, 1'b0);
        end
        check("halt_sticky", halted, 1'b1);
        check("halt_rr_stays", receive_ready, 1'b0);

        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_serial_mem_bridge
